// File: rtl/cpu_switch_if.sv
// Signal bundle between the CPU failover controller and the surrounding switch fabric.
interface cpu_switch_if;
  logic       hb_a;
  logic       hb_b;
  logic       sw_req;
  logic       sw_ack;
  logic       sw_nak;
  logic       ctr_io;
  logic       io_hold;
  logic       alive_a;
  logic       alive_b;
  logic       both_fail;
  logic [7:0] switch_cnt;

  modport master (
    output hb_a, hb_b, sw_req,
    input  sw_ack, sw_nak, ctr_io, io_hold, alive_a, alive_b, both_fail, switch_cnt
  );

  modport slave (
    input  hb_a, hb_b, sw_req,
    output sw_ack, sw_nak, ctr_io, io_hold, alive_a, alive_b, both_fail, switch_cnt
  );
endinterface

// File: rtl/cpu_switch_ctrl.sv
// Dual-CPU I/O ownership failover controller: heartbeat watchdogs, guarded switchover FSM.
// Optional SWITCH_CNT_EN builds the saturating completed-switchover counter.
//
// state  | meaning
// ACT_A  | CPU A owns the I/O pins
// GRD_AB | guard interval, handing A -> B
// ACT_B  | CPU B owns the I/O pins
// GRD_BA | guard interval, handing B -> A
module cpu_switch_ctrl #(
  parameter int WDT_TIMEOUT  = 1000,
  parameter int GUARD_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input logic         clk,
  input logic         rst_n,
  cpu_switch_if.slave bus
);

  localparam int                GW       = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  WDT_MAX  = CNT_W'(WDT_TIMEOUT);
  localparam logic [GW-1:0]     GRD_LOAD = GW'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    ACT_A  = 2'd0,
    GRD_AB = 2'd1,
    ACT_B  = 2'd2,
    GRD_BA = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [GW-1:0]    grd_q, grd_d;
  logic [CNT_W-1:0] wdt_a_q, wdt_a_d, wdt_b_q, wdt_b_d;
  logic             hb_a_q, hb_b_q;
  logic             ack_q, ack_d, nak_q, nak_d;
  logic             ctr_io_q, ctr_io_d, io_hold_q, io_hold_d;
  logic             alive_a, alive_b;

  // Any level change on a heartbeat restarts its watchdog; otherwise count up to the limit.
  always_comb begin
    wdt_a_d = wdt_a_q;
    wdt_b_d = wdt_b_q;
    if (hb_a_q != bus.hb_a)     wdt_a_d = '0;
    else if (wdt_a_q < WDT_MAX) wdt_a_d = wdt_a_q + CNT_W'(1);
    if (hb_b_q != bus.hb_b)     wdt_b_d = '0;
    else if (wdt_b_q < WDT_MAX) wdt_b_d = wdt_b_q + CNT_W'(1);
  end

  assign alive_a = (wdt_a_q < WDT_MAX);
  assign alive_b = (wdt_b_q < WDT_MAX);

  always_comb begin
    state_d = state_q;
    grd_d   = grd_q;
    ack_d   = 1'b0;
    nak_d   = 1'b0;
    case (state_q)
      ACT_A: begin
        if (alive_b && (!alive_a || bus.sw_req)) begin
          state_d = GRD_AB;
          grd_d   = GRD_LOAD;
          ack_d   = bus.sw_req;
        end else begin
          nak_d   = bus.sw_req;
        end
      end
      ACT_B: begin
        if (alive_a && (!alive_b || bus.sw_req)) begin
          state_d = GRD_BA;
          grd_d   = GRD_LOAD;
          ack_d   = bus.sw_req;
        end else begin
          nak_d   = bus.sw_req;
        end
      end
      GRD_AB: begin
        nak_d = bus.sw_req;
        if (grd_q == '0) begin
          // Abort only when the target is dead and the source can still carry on.
          state_d = (alive_b || !alive_a) ? ACT_B : ACT_A;
        end else begin
          grd_d = grd_q - GW'(1);
        end
      end
      GRD_BA: begin
        nak_d = bus.sw_req;
        if (grd_q == '0) begin
          state_d = (alive_a || !alive_b) ? ACT_A : ACT_B;
        end else begin
          grd_d = grd_q - GW'(1);
        end
      end
      default: state_d = ACT_A;
    endcase
    ctr_io_d  = (state_d == ACT_B) || (state_d == GRD_BA);
    io_hold_d = (state_d == GRD_AB) || (state_d == GRD_BA);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACT_A;
      grd_q     <= '0;
      wdt_a_q   <= '0;
      wdt_b_q   <= '0;
      hb_a_q    <= 1'b0;
      hb_b_q    <= 1'b0;
      ack_q     <= 1'b0;
      nak_q     <= 1'b0;
      ctr_io_q  <= 1'b0;
      io_hold_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grd_q     <= grd_d;
      wdt_a_q   <= wdt_a_d;
      wdt_b_q   <= wdt_b_d;
      hb_a_q    <= bus.hb_a;
      hb_b_q    <= bus.hb_b;
      ack_q     <= ack_d;
      nak_q     <= nak_d;
      ctr_io_q  <= ctr_io_d;
      io_hold_q <= io_hold_d;
    end
  end

`ifdef SWITCH_CNT_EN
  logic [7:0] sw_cnt_q;
  logic       cnt_inc;

  assign cnt_inc = ((state_q == GRD_AB) && (state_d == ACT_B)) ||
                   ((state_q == GRD_BA) && (state_d == ACT_A));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_cnt_q <= 8'h00;
    end else if (cnt_inc && (sw_cnt_q != 8'hFF)) begin
      sw_cnt_q <= sw_cnt_q + 8'h01;
    end
  end

  assign bus.switch_cnt = sw_cnt_q;
`else
  assign bus.switch_cnt = 8'h00;
`endif

  assign bus.sw_ack    = ack_q;
  assign bus.sw_nak    = nak_q;
  assign bus.ctr_io    = ctr_io_q;
  assign bus.io_hold   = io_hold_q;
  assign bus.alive_a   = alive_a;
  assign bus.alive_b   = alive_b;
  assign bus.both_fail = !alive_a && !alive_b;

endmodule

// File: tb/tb_cpu_switch_ctrl.sv
// Bench for cpu_switch_ctrl: random heartbeats and requests against a cycle-level ownership model.
module tb_cpu_switch_ctrl;

  localparam int T = 100;
  localparam int G = 4;
`ifdef SWITCH_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  cpu_switch_if sw ();

  cpu_switch_ctrl #(.WDT_TIMEOUT(T), .GUARD_CYCLES(G), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (sw)
  );

  always #5 clk = ~clk;

  logic [14:0] dut_vec;
  assign dut_vec = {sw.ctr_io, sw.io_hold, sw.alive_a, sw.alive_b, sw.both_fail,
                    sw.sw_ack, sw.sw_nak, sw.switch_cnt};

  // Model: ages are unbounded cycle counts since the last beat; guard is "cycles left".
  int          m_age_a, m_age_b, m_left, m_cnt;
  bit          m_prev_a, m_prev_b, m_owner, m_grd, m_ack, m_nak;
  logic [14:0] mexp;

  logic cur_a, cur_b;
  bit   run_a, run_b;
  int   cd_a, cd_b;

  task automatic model_outputs();
    bit la, lb;
    la = (m_age_a < T);
    lb = (m_age_b < T);
    mexp = {m_owner, m_grd, la, lb, (!la && !lb), m_ack, m_nak,
            (CNT_EN ? 8'(m_cnt) : 8'h00)};
  endtask

  task automatic step(input logic a, input logic b, input logic req);
    bit la, lb, own_ok, oth_ok;
    sw.hb_a   = a;
    sw.hb_b   = b;
    sw.sw_req = req;
    @(posedge clk);
    la = (m_age_a < T);
    lb = (m_age_b < T);
    own_ok = m_owner ? lb : la;
    oth_ok = m_owner ? la : lb;
    m_ack = 1'b0;
    m_nak = 1'b0;
    if (!m_grd) begin
      if (oth_ok && (!own_ok || req)) begin
        m_grd  = 1'b1;
        m_left = G;
        m_ack  = req;
      end else begin
        m_nak  = req;
      end
    end else begin
      m_nak  = req;
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_grd = 1'b0;
        if (oth_ok || !own_ok) begin
          m_owner = !m_owner;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end
      end
    end
    m_age_a  = (a != m_prev_a) ? 0 : m_age_a + 1;
    m_age_b  = (b != m_prev_b) ? 0 : m_age_b + 1;
    m_prev_a = a;
    m_prev_b = b;
    model_outputs();
    #1;
  endtask

  task automatic tick(input logic req);
    if (run_a) begin
      if (cd_a == 0) begin cur_a = ~cur_a; cd_a = $urandom_range(1, 20); end
      else cd_a = cd_a - 1;
    end
    if (run_b) begin
      if (cd_b == 0) begin cur_b = ~cur_b; cd_b = $urandom_range(1, 20); end
      else cd_b = cd_b - 1;
    end
    step(cur_a, cur_b, req);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sw.sw_req = 1'b0;
    cur_a = 1'b0; cur_b = 1'b0;
    sw.hb_a = 1'b0; sw.hb_b = 1'b0;
    run_a = 1'b1; run_b = 1'b1;
    cd_a = $urandom_range(1, 20);
    cd_b = $urandom_range(1, 20);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_age_a = 0; m_age_b = 0; m_prev_a = 1'b0; m_prev_b = 1'b0;
    m_owner = 1'b0; m_grd = 1'b0; m_left = 0; m_cnt = 0;
    m_ack = 1'b0; m_nak = 1'b0;
    model_outputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (dut_vec !== 15'b0_0_1_1_0_0_0_00000000) begin
      bad++;
      $display("FAIL reset_state got=%b exp=%b", dut_vec, 15'b0_0_1_1_0_0_0_00000000);
    end
    do_reset();
    total++;
    if (dut_vec !== mexp) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", dut_vec, mexp);
    end
  endtask

  task automatic test_steady();
    bit seen;
    seen = 1'b0;
    do_reset();
    for (int i = 0; i < 1000; i++) begin
      tick(1'b0);
      if (sw.io_hold || sw.ctr_io || !sw.alive_a || !sw.alive_b) seen = 1'b1;
      total++;
      if (dut_vec !== mexp) begin
        bad++;
        $display("FAIL steady cyc=%0d got=%b exp=%b", i, dut_vec, mexp);
      end
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL steady_no_switch got=%b exp=0", seen);
    end
  endtask

  task automatic test_fault_switch();
    int k, h;
    do_reset();
    repeat (50) tick(1'b0);
    run_a = 1'b0;
    cur_a = ~cur_a;
    tick(1'b0);
    k = 0;
    while (sw.alive_a && k < 150) begin
      tick(1'b0);
      k++;
      total++;
      if (dut_vec !== mexp) begin
        bad++;
        $display("FAIL fault_track got=%b exp=%b", dut_vec, mexp);
      end
    end
    total++;
    if (k !== T) begin
      bad++;
      $display("FAIL fault_alive_fall got=%0d exp=%0d", k, T);
    end
    tick(1'b0);
    h = 0;
    while (sw.io_hold && h < 20) begin
      tick(1'b0);
      h++;
    end
    total++;
    if (h !== G) begin
      bad++;
      $display("FAIL fault_hold_len got=%0d exp=%0d", h, G);
    end
    total++;
    if ({sw.ctr_io, sw.switch_cnt} !== {1'b1, (CNT_EN ? 8'd1 : 8'd0)}) begin
      bad++;
      $display("FAIL fault_result got=%b/%0d exp=1/%0d", sw.ctr_io, sw.switch_cnt, CNT_EN ? 1 : 0);
    end
  endtask

  task automatic test_manual();
    int h;
    do_reset();
    repeat (20) tick(1'b0);
    for (int r = 0; r < 2; r++) begin
      tick(1'b1);
      total++;
      if ({sw.sw_ack, sw.sw_nak, sw.io_hold} !== 3'b101) begin
        bad++;
        $display("FAIL manual_ack%0d got=%b exp=101", r, {sw.sw_ack, sw.sw_nak, sw.io_hold});
      end
      h = 1;
      while (sw.io_hold && h < 20) begin
        tick(1'b0);
        if (sw.io_hold) h++;
      end
      total++;
      if (h !== G || sw.ctr_io !== (r == 0)) begin
        bad++;
        $display("FAIL manual_switch%0d got=hold%0d/ctr%b exp=hold%0d/ctr%b", r, h, sw.ctr_io, G, (r == 0));
      end
      repeat (10) begin
        tick(1'b0);
        total++;
        if (dut_vec !== mexp) begin
          bad++;
          $display("FAIL manual_track got=%b exp=%b", dut_vec, mexp);
        end
      end
    end
    total++;
    if (sw.switch_cnt !== (CNT_EN ? 8'd2 : 8'd0)) begin
      bad++;
      $display("FAIL manual_count got=%0d exp=%0d", sw.switch_cnt, CNT_EN ? 2 : 0);
    end
  endtask

  task automatic test_refuse();
    do_reset();
    repeat (10) tick(1'b0);
    run_b = 1'b0;
    repeat (120) tick(1'b0);
    tick(1'b1);
    total++;
    if ({sw.sw_nak, sw.sw_ack, sw.ctr_io, sw.io_hold} !== 4'b1000) begin
      bad++;
      $display("FAIL refuse got=%b exp=1000", {sw.sw_nak, sw.sw_ack, sw.ctr_io, sw.io_hold});
    end
    tick(1'b0);
    total++;
    if (dut_vec !== mexp) begin
      bad++;
      $display("FAIL refuse_after got=%b exp=%b", dut_vec, mexp);
    end
  endtask

  task automatic test_abort();
    do_reset();
    repeat (10) tick(1'b0);
    run_b = 1'b0;
    cur_b = ~cur_b;
    tick(1'b0);
    repeat (96) tick(1'b0);
    tick(1'b1);
    total++;
    if ({sw.sw_ack, sw.io_hold} !== 2'b11) begin
      bad++;
      $display("FAIL abort_start got=%b exp=11", {sw.sw_ack, sw.io_hold});
    end
    repeat (4) tick(1'b0);
    total++;
    if ({sw.ctr_io, sw.io_hold, sw.alive_b, sw.switch_cnt} !== 11'b0) begin
      bad++;
      $display("FAIL abort_result got=%b exp=0", {sw.ctr_io, sw.io_hold, sw.alive_b, sw.switch_cnt});
    end
    total++;
    if (dut_vec !== mexp) begin
      bad++;
      $display("FAIL abort_model got=%b exp=%b", dut_vec, mexp);
    end
  endtask

  task automatic test_reset_mid_guard();
    do_reset();
    repeat (10) tick(1'b0);
    tick(1'b1);
    repeat (4) tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    total++;
    if ({sw.ctr_io, sw.io_hold} !== 2'b11) begin
      bad++;
      $display("FAIL midguard_pre got=%b exp=11", {sw.ctr_io, sw.io_hold});
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({sw.ctr_io, sw.io_hold, sw.switch_cnt} !== 10'b0) begin
      bad++;
      $display("FAIL midguard_reset got=%b exp=0", {sw.ctr_io, sw.io_hold, sw.switch_cnt});
    end
    do_reset();
  endtask

  task automatic test_both_fail();
    int k;
    do_reset();
    repeat (10) tick(1'b0);
    run_a = 1'b0; run_b = 1'b0;
    cur_a = ~cur_a; cur_b = ~cur_b;
    tick(1'b0);
    k = 0;
    while (!sw.both_fail && k < 150) begin
      tick(1'b0);
      k++;
    end
    total++;
    if (k !== T) begin
      bad++;
      $display("FAIL both_fail_time got=%0d exp=%0d", k, T);
    end
    repeat (30) begin
      tick(1'b0);
      total++;
      if (dut_vec !== mexp) begin
        bad++;
        $display("FAIL both_fail_hold got=%b exp=%b", dut_vec, mexp);
      end
    end
    tick(1'b1);
    total++;
    if ({sw.sw_nak, sw.ctr_io, sw.io_hold, sw.both_fail} !== 4'b1001) begin
      bad++;
      $display("FAIL both_fail_req got=%b exp=1001", {sw.sw_nak, sw.ctr_io, sw.io_hold, sw.both_fail});
    end
  endtask

  task automatic test_random();
    logic req;
    do_reset();
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) begin run_a = !run_a; cd_a = $urandom_range(1, 20); end
      if ($urandom_range(0, 149) == 0) begin run_b = !run_b; cd_b = $urandom_range(1, 20); end
      req = ($urandom_range(0, 15) == 0);
      tick(req);
      total++;
      if (dut_vec !== mexp) begin
        bad++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec, mexp);
      end
    end
  endtask

  initial begin
    sw.hb_a = 1'b0;
    sw.hb_b = 1'b0;
    sw.sw_req = 1'b0;
    test_reset();
    test_steady();
    test_fault_switch();
    test_manual();
    test_refuse();
    test_abort();
    test_reset_mid_guard();
    test_both_fail();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_switch_ctrl.md
# cpu_switch_ctrl

Failover controller for the dual-CPU I/O switch fabric. Watches a heartbeat from CPU A and CPU B, decides which CPU owns the shared I/O pins, and drives the `ctr_io` select used by the input/output switch blocks (0 = CPU A, 1 = CPU B). Switchover happens either automatically on a heartbeat timeout or on a software request. A guard interval separates the old owner from the new one.

## Interface
- WDT_TIMEOUT, 1000: cycles without a heartbeat edge before a CPU is declared dead.
- GUARD_CYCLES, 16: guard interval length in cycles. Must be ≥1.
- CNT_W, 16: watchdog counter width. Must satisfy 2^CNT_W > WDT_TIMEOUT.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous reset, active low.
- hb_a  in  1  CPU A heartbeat. Synchronous to clk. Any level change counts as a beat.
- hb_b  in  1  CPU B heartbeat. Same rules as hb_a.
- sw_req  in  1  single-cycle manual switchover request (swap owner).
- sw_ack  out  1  single-cycle pulse: request accepted.
- sw_nak  out  1  single-cycle pulse: request refused.
- ctr_io  out  1  owner select. 0 = CPU A, 1 = CPU B.
- io_hold  out  1  high during the guard interval; I/O consumers freeze.
- alive_a  out  1  CPU A watchdog is not expired.
- alive_b  out  1  CPU B watchdog is not expired.
- both_fail  out  1  both watchdogs are expired.
- switch_cnt  out  8  completed switchovers, saturating (see Configuration).

## Operation
- Heartbeat detect:
  - hb_x is registered once. An edge is declared when the registered value differs from the current input.
  - An edge clears wdt_x to 0. Otherwise wdt_x increments and saturates at WDT_TIMEOUT.
  - alive_x = (wdt_x < WDT_TIMEOUT).
- FSM states: ACT_A, GRD_AB, ACT_B, GRD_BA.
- ACT_A → GRD_AB when either condition holds:
  - !alive_a && alive_b (fault switch), or
  - sw_req && alive_b (manual switch; sw_ack pulses).
- In ACT_A, sw_req with !alive_b is refused: sw_nak pulses and the FSM stays in ACT_A.
- ACT_B → GRD_BA: mirror of the ACT_A rules.
- Guard states:
  - The guard counter loads GUARD_CYCLES−1 on entry and decrements each cycle. io_hold = 1 and ctr_io holds the old value.
  - When the count reaches 0 and the target is alive: move to the target ACT state, toggle ctr_io, increment switch_cnt.
  - When the count reaches 0, the target is dead and the source is alive: abort to the source ACT state. ctr_io is unchanged and there is no count.
  - When the count reaches 0 and both are dead: complete the switch anyway.
- sw_req arriving in a guard state always gets sw_nak.
- sw_req in the same cycle as a fault switch: take the fault switch and pulse sw_ack (not sw_nak).
- Both dead in an ACT state: stay in that state and assert both_fail. No transition occurs.
- Reset values:
  - FSM = ACT_A, ctr_io = 0, io_hold = 0.
  - wdt_a = wdt_b = 0, so alive_a = alive_b = 1.
  - sw_ack = sw_nak = 0, both_fail = 0, switch_cnt = 0.
  - Heartbeat capture registers = 0.
- Reset asserted mid-guard returns to ACT_A immediately, with no switchover counted.

## Timing
- All outputs are registered.
- Heartbeat edge at input cycle n: wdt_x reads 0 at cycle n+1.
- Timeout:
  - alive_x falls exactly WDT_TIMEOUT cycles after the last clear.
  - The FSM enters guard 1 cycle after alive_x falls; io_hold rises in that same cycle.
- ctr_io toggles GUARD_CYCLES cycles after io_hold rises. io_hold falls in the same cycle.
- sw_ack or sw_nak is asserted in the cycle after sw_req, for exactly 1 cycle.
- A switch_cnt increment is visible in the same cycle as the ctr_io toggle.

## Configuration
- SWITCH_CNT_EN defined: the 8-bit saturating counter is built. It counts completed switchovers (not aborts) and saturates at 0xFF.
- SWITCH_CNT_EN undefined: no counter logic is built, switch_cnt is tied to 8'h00, and the port is still present.

## Test plan
All scenarios use WDT_TIMEOUT=100, GUARD_CYCLES=4.
- Reset, both heartbeats toggling every 10 cycles for 1000 cycles → ctr_io=0, io_hold never rises, alive_a=alive_b=1.
- Stop hb_a at cycle t → alive_a falls at t+101; io_hold high for 4 cycles; ctr_io=1; switch_cnt=1.
- In ACT_A with B alive, pulse sw_req → sw_ack 1 cycle later, ctr_io=1 after 4 guard cycles. Pulse sw_req again in ACT_B → ctr_io=0, switch_cnt=2.
- Stop hb_b, wait 120 cycles, pulse sw_req → sw_nak pulse, ctr_io stays 0, io_hold stays 0.
- Start a manual switch to B, then kill hb_b so alive_b falls mid-guard → abort, ctr_io stays 0, switch_cnt unchanged. Assert rst_n=0 mid-guard in a rerun → ctr_io=0, io_hold=0 at once.
- Stop both heartbeats → both_fail=1 after 101 cycles, no transition. Build without SWITCH_CNT_EN → switch_cnt reads 0 after any switch.
